med_window_gen: RTL and testbench
=================================

Name: med_window_gen

Overview:
- Streaming 3x3 window generator that feeds the median sorting network.
- Accepts a raster-order 8-bit pixel stream (image ROM or camera), keeps two line buffers, and emits one full 3x3 neighbourhood per pixel with border padding.
- Lets the median stage consume one pixel per clock instead of three ROM reads per column.

Parameters:
- IMG_W, 224, pixels per line
- IMG_H, 224, lines per frame
- PIX_W, 8, bits per pixel

Ports:
- clk_75  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse, arms frame capture
- in_valid  in  1  pix_in valid this cycle
- pix_in  in  PIX_W  raster pixel
- win_valid  out  1  window valid this cycle
- win  out  9*PIX_W  window, row-major {a11..a33}, a11 at MSBs, a22 = centre
- win_row  out  8  centre row of emitted window
- win_col  out  8  centre column of emitted window
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last window
- overrun  out  1  sticky: in_valid seen while not accepting

Behaviour:
- Reset: win_valid=0, win=0, win_row=0, win_col=0, busy=0, done=0, overrun=0, FSM=IDLE.
- Only clk_75 and rst_n are used. The clock is single and the reset is synchronous, active-low.
- FSM states: IDLE, FILL, RUN, FLUSH, DONE.
  - IDLE: start -> FILL, busy=1. in_valid is ignored, with no overrun.
  - FILL: accept pixels until IMG_W+2 received. The window for centre (0,0) is then complete -> RUN.
  - RUN: every accepted pixel emits exactly one window. After the last input pixel (IMG_H-1, IMG_W-1) -> FLUSH.
  - FLUSH: inject one internal zero pixel per cycle, in_valid not required, for IMG_W+1 cycles. Each injection emits one window -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- start while busy is ignored.
- Window for centre (r,c) is produced when pixel (r+1,c+1) is accepted or injected.
- win_valid, win, win_row and win_col are registered, 1 cycle after the accepting edge.
- Exactly IMG_W*IMG_H windows per frame, in raster order of centre.
- Padding: any tap with row<0, row>IMG_H-1, col<0 or col>IMG_W-1 reads 0. The left column is zeroed at c=0 and the right column at c=IMG_W-1, so there is no wrap from the adjacent line.
- Line buffers: two, depth IMG_W. Write address wraps at IMG_W-1 -> 0. Contents are never cleared; validity comes from the row/col counters only.
- Input gaps (in_valid=0) stall the pipeline. No window is emitted, and state plus counters are held.
- overrun sets when in_valid=1 in FLUSH or DONE. It is cleared only by reset or by start from IDLE.
- rst_n low mid-frame: return to reset values next edge. A partial frame is discarded and no done pulse is produced.
- Counters are widened so IMG_W, IMG_H up to 255 fit; win_row and win_col are 8 bits.

Optional Feature:
- Macro: MED_WINDOW_REPLICATE_BORDER_EN.
- Defined: out-of-image taps replicate the nearest in-image pixel (clamp row/col) instead of 0. Flush-injected pixels are never visible in a window.
- Undefined: zero padding as above.
- Latency, window count and port list are identical in both builds.

Decomposition:
- Package med_pkg holds:
  - PIX_W, IMG_W, IMG_H defaults
  - FSM state enum (IDLE/FILL/RUN/FLUSH/DONE)
  - window tap index constants (A11..A33 bit offsets)
- Sub-module med_line_buffer, instantiated twice:
  - single-clock, IMG_W x PIX_W, one read and one write per accepted pixel
  - read-before-write at the same address
  - inferred block RAM

Test Plan:
- Ramp frame, IMG_W=IMG_H=4, pix=4*r+c+1, in_valid constant:
  - exactly 16 windows
  - centre (1,1) window = {1,2,3,5,6,7,9,10,11}
  - centre (0,0) = {0,0,0,0,1,2,0,5,6}
  - done pulses 1 cycle after the 16th window
- Same frame with in_valid toggling 1,0,1,0: same 16 windows in the same order, and win_valid is never asserted in a stall cycle.
- Corner (3,3) with zero padding = {11,12,0,15,16,0,0,0,0}. With MED_WINDOW_REPLICATE_BORDER_EN = {11,12,12,15,16,16,15,16,16}.
- rst_n low after 7 pixels, then start and a full ramp frame:
  - first window is centre (0,0) with correct values
  - no done is produced for the aborted frame
- in_valid=1 during FLUSH: overrun=1 and the window stream is unchanged. The next start from IDLE clears overrun.
- Default 224x224 frame from the image ROM: 50176 windows, last win_row=223, win_col=223, then a single done pulse.

Source files
------------

// File: rtl/med_pkg.sv
// Shared definitions for the 3x3 median window generator: default geometry,
// FSM state encoding and window tap slot indices.
package med_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 224;
    localparam int DEF_IMG_H = 224;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Tap slots in the packed window; bit offset of a tap = slot * PIX_W.
    // a11 (top-left) sits at the MSBs, a33 (bottom-right) at the LSBs.
    localparam int A11 = 8;
    localparam int A12 = 7;
    localparam int A13 = 6;
    localparam int A21 = 5;
    localparam int A22 = 4;
    localparam int A23 = 3;
    localparam int A31 = 2;
    localparam int A32 = 1;
    localparam int A33 = 0;

endpackage

// File: rtl/med_line_buffer.sv
// One image line of storage with a registered read port; a read and a write
// to the same address in one cycle return the previous contents.
module med_line_buffer #(
    parameter int DEPTH = 224,
    parameter int WIDTH = 8,
    parameter int AW    = 8
) (
    input  logic             clk_75,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write and registered read, read-first on collision.
    // NOTE: no reset here -- a reset would stop the array mapping onto block
    // RAM, and stale contents are never visible because padding is driven by
    // the row/column counters.
    // NOTE: non-blocking assignments make the read sample the old word even
    // when the write targets the same address in the same edge.
    always_ff @(posedge clk_75) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/med_window_gen.sv
// Streaming 3x3 window generator for the median filter. Two line buffers plus
// a two-column shift register rebuild the neighbourhood of every pixel; border
// taps are zero padded, or replicated from the nearest in-image pixel when
// MED_WINDOW_REPLICATE_BORDER_EN is defined.
module med_window_gen
    import med_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic               clk_75,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [PIX_W-1:0]   pix_in,
    output logic               win_valid,
    output logic [9*PIX_W-1:0] win,
    output logic [7:0]         win_row,
    output logic [7:0]         win_col,
    output logic               busy,
    output logic               done,
    output logic               overrun
);

    localparam logic [7:0] COL_LAST    = 8'(IMG_W - 1);
    localparam logic [7:0] ROW_LAST    = 8'(IMG_H - 1);
    localparam logic [8:0] IN_ROW_LAST = 9'(IMG_H - 1);

    state_t             state, next_state;
    logic [7:0]         in_col, in_col_nxt, rd_addr;
    logic [8:0]         in_row;
    logic [7:0]         ctr_row, ctr_col;
    logic               accept, emit;
    logic [PIX_W-1:0]   pix_eff, rd_a, rd_b;
    // Columns are packed {top, mid, bottom}; col_l/col_m are the left and
    // middle columns of the next window, col_new is the arriving column.
    logic [3*PIX_W-1:0] col_l, col_m, col_new;
    logic [9*PIX_W-1:0] win_nxt;

    assign busy = (state != IDLE);

    // lb_a holds the line above the input pixel, lb_b the line above that.
    med_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(8)) u_lb_a (
        .clk_75 (clk_75),
        .we     (accept),
        .waddr  (in_col),
        .wdata  (pix_eff),
        .raddr  (rd_addr),
        .rdata  (rd_a)
    );

    med_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(8)) u_lb_b (
        .clk_75 (clk_75),
        .we     (accept),
        .waddr  (in_col),
        .wdata  (rd_a),
        .raddr  (rd_addr),
        .rdata  (rd_b)
    );

    // Next-state logic plus accept/emit strobes for the current cycle.
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        emit       = 1'b0;
        pix_eff    = pix_in;
        case (state)
            IDLE: begin
                if (start) next_state = FILL;
            end
            FILL: begin
                accept = in_valid;
                emit   = in_valid && (in_row == 9'd1) && (in_col == 8'd1);
                if (emit) next_state = RUN;
            end
            RUN: begin
                accept = in_valid;
                emit   = in_valid;
                if (in_valid && (in_row == IN_ROW_LAST) && (in_col == COL_LAST))
                    next_state = FLUSH;
            end
            FLUSH: begin
                accept  = 1'b1;
                emit    = 1'b1;
                pix_eff = '0;
                if ((ctr_row == ROW_LAST) && (ctr_col == COL_LAST))
                    next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        in_col_nxt = (in_col == COL_LAST) ? 8'd0 : in_col + 8'd1;
        // Prefetch the column the next accepted pixel will need.
        rd_addr    = accept ? in_col_nxt : in_col;
        col_new    = {rd_b, rd_a, pix_eff};
    end

    // Assemble the raw 3x3 taps and apply border handling for the centre.
    always_comb begin
        logic [PIX_W-1:0] tp [3][3];
        for (int r = 0; r < 3; r++) begin
            tp[r][0] = col_l[(2-r)*PIX_W +: PIX_W];
            tp[r][1] = col_m[(2-r)*PIX_W +: PIX_W];
            tp[r][2] = col_new[(2-r)*PIX_W +: PIX_W];
        end
`ifdef MED_WINDOW_REPLICATE_BORDER_EN
        // Rows first, then columns, so corners pick up the in-image centre row.
        if (ctr_row == 8'd0)     for (int c = 0; c < 3; c++) tp[0][c] = tp[1][c];
        if (ctr_row == ROW_LAST) for (int c = 0; c < 3; c++) tp[2][c] = tp[1][c];
        if (ctr_col == 8'd0)     for (int r = 0; r < 3; r++) tp[r][0] = tp[r][1];
        if (ctr_col == COL_LAST) for (int r = 0; r < 3; r++) tp[r][2] = tp[r][1];
`else
        if (ctr_row == 8'd0)     for (int c = 0; c < 3; c++) tp[0][c] = '0;
        if (ctr_row == ROW_LAST) for (int c = 0; c < 3; c++) tp[2][c] = '0;
        if (ctr_col == 8'd0)     for (int r = 0; r < 3; r++) tp[r][0] = '0;
        if (ctr_col == COL_LAST) for (int r = 0; r < 3; r++) tp[r][2] = '0;
`endif
        win_nxt = '0;
        win_nxt[A11*PIX_W +: PIX_W] = tp[0][0];
        win_nxt[A12*PIX_W +: PIX_W] = tp[0][1];
        win_nxt[A13*PIX_W +: PIX_W] = tp[0][2];
        win_nxt[A21*PIX_W +: PIX_W] = tp[1][0];
        win_nxt[A22*PIX_W +: PIX_W] = tp[1][1];
        win_nxt[A23*PIX_W +: PIX_W] = tp[1][2];
        win_nxt[A31*PIX_W +: PIX_W] = tp[2][0];
        win_nxt[A32*PIX_W +: PIX_W] = tp[2][1];
        win_nxt[A33*PIX_W +: PIX_W] = tp[2][2];
    end

    // State, counters, column shift register and registered outputs.
    always_ff @(posedge clk_75) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_valid <= 1'b0;
            win       <= '0;
            win_row   <= '0;
            win_col   <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            in_col    <= '0;
            in_row    <= '0;
            ctr_row   <= '0;
            ctr_col   <= '0;
            col_l     <= '0;
            col_m     <= '0;
        end else begin
            state     <= next_state;
            win_valid <= emit;
            done      <= (state == DONE);
            if ((state == IDLE) && start) begin
                overrun <= 1'b0;
                in_col  <= '0;
                in_row  <= '0;
                ctr_row <= '0;
                ctr_col <= '0;
            end
            if (((state == FLUSH) || (state == DONE)) && in_valid) begin
                overrun <= 1'b1;
            end
            if (state == DONE) begin
                in_col <= '0;
            end
            if (accept) begin
                in_col <= in_col_nxt;
                if (in_col == COL_LAST) in_row <= in_row + 9'd1;
                col_l  <= col_m;
                col_m  <= col_new;
            end
            if (emit) begin
                win     <= win_nxt;
                win_row <= ctr_row;
                win_col <= ctr_col;
                if (ctr_col == COL_LAST) begin
                    ctr_col <= '0;
                    ctr_row <= ctr_row + 8'd1;
                end else begin
                    ctr_col <= ctr_col + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_med_window_gen.sv
// Self-checking bench for med_window_gen: a 4x4 instance exercised with
// directed frames against a scoreboard, plus a default 224x224 instance.
module tb_med_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int BW = 224;
    localparam int BH = 224;

    logic clk_75 = 1'b0;
    always #5 clk_75 = ~clk_75;

    logic          rst_n, start, in_valid;
    logic [PW-1:0] pix_in;
    logic          win_valid, busy, done, overrun;
    logic [71:0]   win;
    logic [7:0]    win_row, win_col;

    logic          b_start, b_in_valid;
    logic [7:0]    b_pix_in;
    logic          b_win_valid, b_busy, b_done, b_overrun;
    logic [71:0]   b_win;
    logic [7:0]    b_win_row, b_win_col;

    med_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk_75(clk_75), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .pix_in(pix_in), .win_valid(win_valid), .win(win), .win_row(win_row),
        .win_col(win_col), .busy(busy), .done(done), .overrun(overrun)
    );

    med_window_gen dut_big (
        .clk_75(clk_75), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
        .pix_in(b_pix_in), .win_valid(b_win_valid), .win(b_win), .win_row(b_win_row),
        .win_col(b_win_col), .busy(b_busy), .done(b_done), .overrun(b_overrun)
    );

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  c;
        logic [71:0] w;
    } exp_t;

    exp_t        sbq [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        prev_iv = 1'b0;
    logic        stall_chk = 1'b0;
    int          n_win = 0, n_done = 0, last_win_cyc = 0, done_cyc = 0;
    logic        got_first = 1'b0;
    logic [71:0] first_win;
    logic [7:0]  first_row, first_col;
    logic [71:0] cap [H][W];
    logic [7:0]  img [H][W];

    int          b_cnt = 0, b_bad = 0, b_done_cnt = 0, b_done_cyc = 0, b_last_cyc = 0;
    int          b_exp_r = 0, b_exp_c = 0;
    logic [7:0]  b_last_r = 8'd0, b_last_c = 8'd0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [71:0] model_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                int rr, cc;
                logic [7:0] v;
                rr = r + dr - 1;
                cc = c + dc - 1;
`ifdef MED_WINDOW_REPLICATE_BORDER_EN
                if (rr < 0) rr = 0;
                if (rr > H - 1) rr = H - 1;
                if (cc < 0) cc = 0;
                if (cc > W - 1) cc = W - 1;
                v = img[rr][cc];
`else
                if (rr < 0 || rr > H - 1 || cc < 0 || cc > W - 1) v = 8'd0;
                else v = img[rr][cc];
`endif
                w[(8 - (3*dr + dc))*8 +: 8] = v;
            end
        end
        return w;
    endfunction

    function automatic logic [7:0] bpix(input int r, input int c);
        return 8'(r*7 + c*3 + 1);
    endfunction

    // Pixel-clock bookkeeping for the stall and done-latency checks.
    always @(posedge clk_75) begin
        cyc     <= cyc + 1;
        prev_iv <= in_valid;
    end

    // Scoreboard monitor for the 4x4 instance.
    always @(negedge clk_75) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            got_first = 1'b0;
        end else begin
            if (stall_chk && !prev_iv) check("stall_no_win", win_valid, 1'b0);
            if (win_valid) begin
                n_win++;
                last_win_cyc = cyc;
                if (win_row < 8'(H) && win_col < 8'(W)) cap[win_row[1:0]][win_col[1:0]] = win;
                if (!got_first) begin
                    first_win = win;
                    first_row = win_row;
                    first_col = win_col;
                    got_first = 1'b1;
                end
                check("sb_has_entry", sbq.size() > 0, 1'b1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("win", win, e.w);
                    check("win_row", win_row, e.r);
                    check("win_col", win_col, e.c);
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // Monitor for the full-size instance: raster order, centre and top taps.
    always @(negedge clk_75) begin
        logic [7:0] exp_top;
        if (rst_n) begin
            if (b_win_valid) begin
`ifdef MED_WINDOW_REPLICATE_BORDER_EN
                exp_top = (b_exp_r == 0) ? bpix(0, b_exp_c) : bpix(b_exp_r - 1, b_exp_c);
`else
                exp_top = (b_exp_r == 0) ? 8'd0 : bpix(b_exp_r - 1, b_exp_c);
`endif
                if (b_win_row !== 8'(b_exp_r) || b_win_col !== 8'(b_exp_c) ||
                    b_win[39:32] !== bpix(b_exp_r, b_exp_c) || b_win[63:56] !== exp_top)
                    b_bad++;
                b_cnt++;
                b_last_r   = b_win_row;
                b_last_c   = b_win_col;
                b_last_cyc = cyc;
                if (b_exp_c == BW - 1) begin
                    b_exp_c = 0;
                    b_exp_r++;
                end else begin
                    b_exp_c++;
                end
            end
            if (b_done) begin
                b_done_cnt++;
                b_done_cyc = cyc;
            end
        end
    end

    task automatic load_frame(input int base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'(base + 4*r + c + 1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                sbq.push_back('{r: 8'(r), c: 8'(c), w: model_win(r, c)});
    endtask

    task automatic start_frame();
        start = 1'b1;
        @(posedge clk_75); #1;
        start = 1'b0;
    endtask

    task automatic drive_pixels(input bit toggle, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            pix_in   = img[k / W][k % W];
            @(posedge clk_75); #1;
            if (toggle && k < n - 1) begin
                in_valid = 1'b0;
                @(posedge clk_75); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk_75);
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        @(negedge clk_75);
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic run_frame(input string tag, input int base, input bit toggle,
                             input bit flush_iv, input bit ovr_clr_chk);
        int w0, d0;
        w0 = n_win;
        d0 = n_done;
        load_frame(base);
        start_frame();
        if (ovr_clr_chk) check({tag, "_overrun_cleared"}, overrun, 1'b0);
        check({tag, "_busy_high"}, busy, 1'b1);
        stall_chk = toggle;
        drive_pixels(toggle, W*H);
        stall_chk = 1'b0;
        if (flush_iv) begin
            in_valid = 1'b1;
            pix_in   = 8'hEE;
            repeat (3) begin
                @(posedge clk_75); #1;
            end
            in_valid = 1'b0;
        end
        wait_done(tag);
        check({tag, "_windows"}, n_win - w0, W*H);
        check({tag, "_dones"}, n_done - d0, 1);
        check({tag, "_done_latency"}, done_cyc, last_win_cyc + 1);
        check({tag, "_sb_drained"}, sbq.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; pix_in = '0;
        b_start = 1'b0; b_in_valid = 1'b0; b_pix_in = '0;
        repeat (2) @(posedge clk_75);
        #1;
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_win", win, 72'd0);
        check("rst_win_row", win_row, 8'd0);
        check("rst_win_col", win_col, 8'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;

        // in_valid while idle is ignored and never flags overrun
        in_valid = 1'b1; pix_in = 8'h55;
        repeat (3) begin
            @(posedge clk_75); #1;
        end
        in_valid = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("idle_overrun", overrun, 1'b0);
        check("idle_no_windows", n_win, 0);

        // ramp frame, continuous input
        run_frame("ramp", 0, 1'b0, 1'b0, 1'b0);
        check("ramp_c11", cap[1][1], {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
`ifdef MED_WINDOW_REPLICATE_BORDER_EN
        check("ramp_c00", cap[0][0], {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd5, 8'd5, 8'd6});
        check("ramp_c33", cap[3][3], {8'd11, 8'd12, 8'd12, 8'd15, 8'd16, 8'd16, 8'd15, 8'd16, 8'd16});
`else
        check("ramp_c00", cap[0][0], {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6});
        check("ramp_c33", cap[3][3], {8'd11, 8'd12, 8'd0, 8'd15, 8'd16, 8'd0, 8'd0, 8'd0, 8'd0});
`endif

        // same frame with a 1,0,1,0 in_valid pattern
        run_frame("toggle", 0, 1'b1, 1'b0, 1'b0);

        // abort after 7 pixels
        load_frame(0);
        start_frame();
        drive_pixels(1'b0, 7);
        d0 = n_done;
        rst_n = 1'b0;
        @(posedge clk_75); #1;
        rst_n = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_win_valid", win_valid, 1'b0);
        repeat (20) @(posedge clk_75);
        #1;
        check("abort_no_done", n_done - d0, 0);
        run_frame("after_abort", 0, 1'b0, 1'b0, 1'b0);
        check("first_row", first_row, 8'd0);
        check("first_col", first_col, 8'd0);
`ifdef MED_WINDOW_REPLICATE_BORDER_EN
        check("first_win", first_win, {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd5, 8'd5, 8'd6});
`else
        check("first_win", first_win, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6});
`endif

        // in_valid during flush: sticky overrun, unchanged stream
        run_frame("ovr", 100, 1'b0, 1'b1, 1'b0);
        check("ovr_sticky", overrun, 1'b1);
        run_frame("ovr_next", 50, 1'b0, 1'b0, 1'b1);

        // default-size frame
        b_start = 1'b1;
        @(posedge clk_75); #1;
        b_start = 1'b0;
        for (int r = 0; r < BH; r++) begin
            for (int c = 0; c < BW; c++) begin
                b_in_valid = 1'b1;
                b_pix_in   = bpix(r, c);
                @(posedge clk_75); #1;
            end
        end
        b_in_valid = 1'b0;
        n = 0;
        while (b_done !== 1'b1 && n < 2000) begin
            @(negedge clk_75);
            n++;
        end
        check("big_done_seen", b_done, 1'b1);
        @(negedge clk_75);
        check("big_windows", b_cnt, BW*BH);
        check("big_bad_windows", b_bad, 0);
        check("big_last_row", b_last_r, 8'd223);
        check("big_last_col", b_last_c, 8'd223);
        check("big_dones", b_done_cnt, 1);
        check("big_done_latency", b_done_cyc, b_last_cyc + 1);
        check("big_overrun", b_overrun, 1'b0);
        check("big_busy_low", b_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
